// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with pipeline stall
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [4:0]            rd_in,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            rd_out
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_INT  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state, state_next;
    logic [4:0]     count;
    logic [2:0]     op_r;
    logic [4:0]     rd_r;
    logic           neg;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc;

    logic           signed_a, signed_b, a_neg, b_neg, is_div;
    logic [W-1:0]   a_abs, b_abs;
    logic           div_zero, div_ovf, fast, neg_init, launch;
    logic [W-1:0]   fast_res;

    always_comb begin
        signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = signed_a && a[W-1];
        b_neg    = signed_b && b[W-1];
        a_abs    = a_neg ? (~a + 1'b1) : a;
        b_abs    = b_neg ? (~b + 1'b1) : b;
        is_div   = op[2];
        div_zero = is_div && (b == '0);
        div_ovf  = ((op == 3'b100) || (op == 3'b110)) && (a == MIN_INT) && (b == ALL_ONES);
        fast     = div_zero || div_ovf;
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero)
            fast_res = op[1] ? a : ALL_ONES;
        else
            fast_res = op[1] ? '0 : MIN_INT;
        if (is_div && op[1])
            neg_init = a_neg;
        else
            neg_init = a_neg ^ b_neg;
        launch = (state == IDLE) && start && !flush;
    end

    // Iteration step: multiply keeps {partial, multiplier}, divide keeps {remainder, quotient}
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift, div_diff;
    logic [2*W-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        mul_next  = {mul_sum, acc[W-1:1]};
        div_shift = acc[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (div_diff[W])
            div_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
        else
            div_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = neg ? (~acc + 1'b1) : acc;
        quot_fix = neg ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        rem_fix  = neg ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
        case (op_r)
            3'b000:                 fix_res = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
            3'b100, 3'b101:         fix_res = quot_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    stall      = 1'b1;
                    state_next = fast ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (count == 5'd31)
                    state_next = FIX;
            end
            FIX: begin
                stall      = 1'b1;
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            op_r   <= '0;
            rd_r   <= '0;
            neg    <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            state <= state_next;
            if (flush) begin
                count <= '0;
            end else if (launch) begin
                op_r  <= op;
                rd_r  <= rd_in;
                neg   <= neg_init;
                count <= '0;
                opnd  <= is_div ? b_abs : a_abs;
                acc   <= {{W{1'b0}}, is_div ? a_abs : b_abs};
                if (fast) begin
                    result <= fast_res;
                    rd_out <= rd_in;
                end
            end else if (state == CALC) begin
                count <= count + 5'd1;
                acc   <= op_r[2] ? div_next : mul_next;
            end else if (state == FIX) begin
                result <= fix_res;
                rd_out <= rd_r;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit stall_ok;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b; rd_in = v.rd;
        #1;
        stall_ok = (stall === 1'b1);
        lat = 0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) lat = c;
            if (stall !== ((c < v.exp_lat) ? 1'b1 : 1'b0)) stall_ok = 1'b0;
            start = 1'b0;
            a = $urandom; b = $urandom; rd_in = 5'($urandom);
        end
        check($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("vec%0d result", idx), result, v.exp_res);
        check($sformatf("vec%0d rd_out", idx), {27'd0, rd_out}, {27'd0, v.rd});
        check($sformatf("vec%0d stall_profile", idx), {31'd0, stall_ok}, 32'd1);
        @(negedge clk);
        check($sformatf("vec%0d done_one_cycle", idx), {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        bit saw_done;
        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 34};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       34};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        34};
        vecs[8]  = '{3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1};

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; rd_in = '0; flush = 1'b0;
        #1;
        check("reset_result", result, 32'd0);
        check("reset_rd_out", {27'd0, rd_out}, 32'd0);
        check("reset_flags", {29'd0, stall, busy, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Flush a MUL in its cycle 10: back to IDLE, no done, outputs keep the last result
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4; rd_in = 5'd9;
        saw_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) saw_done = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle", {30'd0, busy, stall}, 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("flush_no_done", {31'd0, saw_done}, 32'd0);
        check("flush_result_kept", result, vecs[11].exp_res);
        check("flush_rd_kept", {27'd0, rd_out}, {27'd0, vecs[11].rd});

        // start and flush together in IDLE: nothing launches
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b101; a = 32'd9; b = 32'd3;
        #1;
        check("flush_start_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        run_vec(12, '{3'b101, 32'd9, 32'd3, 5'd21, 32'd3, 34});

        // Reset in cycle 20 of a DIV
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7; rd_in = 5'd3;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midreset_result", result, 32'd0);
        check("midreset_rd_out", {27'd0, rd_out}, 32'd0);
        check("midreset_flags", {29'd0, stall, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("postreset_idle", {31'd0, saw_done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the Execute stage.
- Consumes the register operands, immediate-free funct3 and destination register produced by the Decode/Execute pipeline register.
- Holds the pipeline via stall while computing, then presents a one-cycle result alongside the ALU path.
- Radix-2 shift-add multiply and restoring divide share one 64-bit datapath.

Parameters:
DATA_WIDTH, 32, operand/result width (only 32 is supported; the cycle counts below assume it)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  Execute-stage instruction is an M-extension op (MulDivE)
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  DATA_WIDTH  rs1 operand (RD1E after forwarding)
b  input  DATA_WIDTH  rs2 operand (RD2E after forwarding)
rd_in  input  5  destination register (RdE)
flush  input  1  synchronous kill from hazard unit (branch/jump taken)
stall  output  1  freezes PC, F/D and D/E registers while high
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: result and rd_out valid
result  output  DATA_WIDTH  final result, held until next done
rd_out  output  5  destination register captured at start

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset (async, rst_n=0): state IDLE, count 0, result 0, rd_out 0, done 0, internal accumulators 0.
- IDLE: start=1 and flush=0 at an edge captures op, rd_in and |a|, |b| (sign taken per op: MULH/DIV/REM both signed, MULHSU a only, others unsigned), records result sign, count<=0, goes to CALC.
- Fast path at the IDLE edge, going straight to DONE:
  - b==0 on a divide op: DIV/DIVU result 0xFFFFFFFF; REM/REMU result a.
  - a==0x80000000 and b==0xFFFFFFFF on DIV/REM: DIV result 0x80000000; REM result 0.
- CALC: one iteration per cycle, count increments, leaves after count==31, i.e. 32 cycles, into FIX.
  - Multiply: 64-bit shift-add.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX (1 cycle), result selection and sign correction:
  - MUL: low word of the product.
  - MULH/MULHSU/MULHU: high word of the two's-complement product after negation if the sign flag is set.
  - DIV/DIVU: quotient, negated if sign(a) xor sign(b) for DIV.
  - REM/REMU: remainder, negated to take sign(a) for REM.
  - FIX writes result and goes to DONE.
- DONE: done=1 for exactly this cycle, stall=0, next edge unconditionally IDLE. start seen in DONE is the same instruction still in E and is ignored.
- Latency: start high in cycle 0 gives done in cycle 34 (normal path) or cycle 1 (fast path).
- stall = (state==IDLE & start & ~flush) | state==CALC | state==FIX. This is combinational so the first cycle already stalls.
- flush: from any state, the next edge goes to IDLE, count 0, no done pulse, result keeps its previous value. flush and start together in IDLE: flush wins, no operation is started.
- rst_n low mid-operation: immediate return to reset values. No done pulse after release.
- result and rd_out only change at FIX or fast-path capture. They are stable otherwise.
- busy=1 in CALC, FIX, DONE.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, start in cycle 0 -> stall high cycles 0-33, done only in cycle 34, result 0xFFFFFFEB, rd_out = rd_in.
- MULH a=b=0x80000000 -> result 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done in cycle 1, result 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM same operands -> 0.
- Start MUL, assert flush in cycle 10 -> IDLE at cycle 11, no done, result unchanged. Then start DIVU 9/3 -> 3 at cycle 34 relative to its start.
- Pull rst_n low in cycle 20 of a DIV -> all outputs 0 asynchronously. After release with start=0, remain IDLE with no done.
